fib_datapath: RTL and testbench
===============================

// Module: fib_datapath
// PURPOSE
//  Datapath driven by the Fibonacci control FSM. It consumes clr/up/ld/we and returns rco
//  (packed into the FSM status input as x_in[0]). It holds the address counter, the F(n) and
//  F(n+1) registers, the adder and a DEPTH-word sequence RAM. The RAM also has a registered
//  read port for the display/readout logic.
// PARAMETERS
//  DATA_W  8   width of each Fibonacci term and RAM word
//  ADDR_W  4   width of the address counter; DEPTH = 2**ADDR_W words
// PORTS
//  clk      in   1       system clock, all state updates on rising edge
//  rst_n    in   1       asynchronous, active-low reset
//  clr      in   1       synchronous clear of address counter
//  up       in   1       increment address counter
//  ld       in   1       load seed terms (F0=0, F1=1)
//  we       in   1       write current term to RAM[cnt] and advance the sequence
//  rco      out  1       ripple-carry: 1 while cnt == DEPTH-1 (combinational from cnt)
//  cnt      out  ADDR_W  current write address
//  rd_addr  in   ADDR_W  readout address
//  rd_data  out  DATA_W  RAM[rd_addr], registered, 1-cycle latency
//  ovf      out  1       overflow flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0, async): cnt=0, a=0, b=1, rd_data=0, ovf=0. RAM contents are not reset.
//   Mid-run reset: all registers return to their reset values immediately. Any write in
//   that cycle is suppressed. The FSM is not reset by this block.
//  Address counter, per edge:
//   - clr=1 -> cnt<=0 (clr beats up)
//   - else up=1 -> cnt<=cnt+1, wrapping DEPTH-1 -> 0
//   - else hold
//   - Free-running in FSM WAIT state (up=1) is legal and harmless.
//  Term registers a (=F(n)) and b (=F(n+1)), per edge:
//   - ld=1 -> a<=0, b<=1. ld beats we; no RAM write that cycle.
//   - else we=1 -> RAM[cnt]<=a, a<=b, b<=a+b (DATA_W-bit add, overflow per CONFIGURATION).
//   - else hold
//  rco = (cnt == DEPTH-1). With the FSM, FIB cycle k writes F(k) at address k.
//   - In the cycle with cnt=DEPTH-1: rco=1, the FSM writes the last word, cnt wraps to 0,
//     and the FSM returns to WAIT.
//   - Exactly DEPTH words are written per run: F0..F(DEPTH-1).
//  Read port: rd_data<=RAM[rd_addr] every edge.
//   - Same-address read and write in one cycle returns the OLD word (read-before-write).
//  clr and ld together: both take effect (they act on disjoint registers).
//  we=1 with up=0: writes and advances the terms; cnt holds, so the next write overwrites.
// CONFIGURATION
//  FIB_SAT_EN defined:
//   - adder saturates: if a+b > 2**DATA_W-1 then b<=all-ones.
//   - ovf sets sticky on the first saturating we; cleared only by ld or reset.
//   - Once saturated, later terms stay all-ones.
//  FIB_SAT_EN undefined:
//   - sum wraps modulo 2**DATA_W.
//   - ovf is tied to 0.
// TESTING (DATA_W=8, ADDR_W=4)
//  1. Reset, clr=1 one cycle, then ld=1 one cycle, then we=up=1 for 16 cycles
//     -> RAM[0..12] = 0,1,1,2,3,5,8,13,21,34,55,89,144.
//     Without FIB_SAT_EN: RAM[13..15] = 233,121,98.
//  2. Same run with FIB_SAT_EN -> RAM[13..15] = 233,255,255.
//     ovf rises on the edge that writes 255 into b (after RAM[12] written), stays 1;
//     next ld clears it.
//  3. rco timing -> rco=1 exactly in the cycle cnt=15, RAM[15] written that edge,
//     cnt=0 next cycle. Also clr=1 and up=1 together -> cnt=0.
//  4. Readout: rd_addr=7 -> rd_data=13 one cycle later.
//     rd_addr=cnt during a write -> previous contents returned.
//  5. Mid-run reset: assert rst_n=0 at cnt=5 -> cnt=0, a=0, b=1, rd_data=0 asynchronously.
//     RAM[0..4] keep their values; no write at address 5.
//  6. ld=1 and we=1 same cycle -> a=0, b=1, RAM[cnt] unchanged.

Source files
------------

// File: rtl/fib_datapath_if.sv
// Datapath handshake bundle between the Fibonacci control FSM (master) and fib_datapath (slave).
// Combinational wiring only, so it adds no latency and has no backpressure.
interface fib_datapath_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              clr;
    logic              up;
    logic              ld;
    logic              we;
    logic              rco;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              ovf;

    modport master (
        output clr, up, ld, we, rd_addr,
        input  rco, cnt, rd_data, ovf
    );

    modport slave (
        input  clr, up, ld, we, rd_addr,
        output rco, cnt, rd_data, ovf
    );
endinterface

// File: rtl/fib_datapath.sv
// Fibonacci datapath: address counter, F(n)/F(n+1) term registers, adder and sequence RAM.
// Latency: state updates on the clock edge; rd_data is RAM[rd_addr] one cycle later.
// Backpressure: none; FIB_SAT_EN selects a saturating adder with a sticky ovf flag.
module fib_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    fib_datapath_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] b_next;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;

    // ld wins over we, so seeding never disturbs the RAM.
    assign wr_en = bus.we & ~bus.ld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (bus.clr) begin
            cnt <= '0;
        end else if (bus.up) begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef FIB_SAT_EN
    logic [DATA_W:0] sum_w;
    logic            sat;
    logic            ovf_q;

    assign sum_w  = {1'b0, a} + {1'b0, b};
    assign sat    = sum_w[DATA_W];
    assign b_next = sat ? '1 : sum_w[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (bus.ld) begin
            ovf_q <= 1'b0;
        end else if (bus.we && sat) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign b_next  = a + b;
    assign bus.ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a <= '0;
            b <= DATA_W'(1);
        end else if (bus.ld) begin
            a <= '0;
            b <= DATA_W'(1);
        end else if (bus.we) begin
            a <= b;
            b <= b_next;
        end
    end

    // RAM is not reset; gating on rst_n drops any write that lands while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[cnt] <= a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[bus.rd_addr];
        end
    end

    assign bus.rco     = (cnt == ADDR_W'(DEPTH - 1));
    assign bus.cnt     = cnt;
    assign bus.rd_data = rd_q;
endmodule

// File: tb/tb_fib_datapath.sv
// Self-checking bench for fib_datapath: vector tables, directed corner sequences and a random
// phase compared against an arithmetic reference model of the Fibonacci datapath.
module tb_fib_datapath;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;
`ifdef FIB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    fib_datapath_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    fib_datapath #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    int m_cnt, m_a, m_b, m_ovf, m_rd;
    bit m_rdv;
    int m_mem  [DEPTH];
    bit m_memv [DEPTH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_a = 0; m_b = 1; m_ovf = 0; m_rd = 0; m_rdv = 1'b1;
    endtask

    task automatic model_edge(input bit c, input bit u, input bit l, input bit w, input int ra);
        int nrd;
        bit nrdv;
        int sum;
        nrd  = m_mem[ra];
        nrdv = m_memv[ra];
        if (w && !l) begin
            m_mem[m_cnt]  = m_a;
            m_memv[m_cnt] = 1'b1;
        end
        if (c)      m_cnt = 0;
        else if (u) m_cnt = (m_cnt + 1) % DEPTH;
        if (l) begin
            m_a = 0; m_b = 1; m_ovf = 0;
        end else if (w) begin
            sum = m_a + m_b;
            m_a = m_b;
            if (SAT && sum > 255) begin
                m_b   = 255;
                m_ovf = 1;
            end else begin
                m_b = sum % 256;
            end
        end
        m_rd  = nrd;
        m_rdv = nrdv;
    endtask

    // Called at a negedge: drive, take one edge, then compare at the following negedge.
    task automatic cyc(input bit c, input bit u, input bit l, input bit w, input int ra);
        bus.clr = c; bus.up = u; bus.ld = l; bus.we = w; bus.rd_addr = 4'(ra);
        @(posedge clk);
        model_edge(c, u, l, w, ra);
        @(negedge clk);
        chk("cnt", 32'(bus.cnt), 32'(m_cnt));
        chk("rco", 32'(bus.rco), 32'(m_cnt == DEPTH - 1));
        chk("ovf", 32'(bus.ovf), 32'(m_ovf));
        chk("a", 32'(dut.a), 32'(m_a));
        chk("b", 32'(dut.b), 32'(m_b));
        if (m_rdv) chk("rd_data", 32'(bus.rd_data), 32'(m_rd));
    endtask

    initial begin
        rd_vec_t tbl [DEPTH];
        int      seq [DEPTH];
        tests = 0;
        fails = 0;
        seq = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};
        if (SAT) begin
            seq[14] = 255;
            seq[15] = 255;
        end
        for (int i = 0; i < DEPTH; i++) begin
            tbl[i].addr = 4'(i);
            tbl[i].exp  = 8'(seq[i]);
            m_mem[i]    = 0;
            m_memv[i]   = 1'b0;
        end

        bus.clr = 0; bus.up = 0; bus.ld = 0; bus.we = 0; bus.rd_addr = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_cnt", 32'(bus.cnt), 0);
        chk("rst_rco", 32'(bus.rco), 0);
        chk("rst_rd", 32'(bus.rd_data), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        chk("rst_a", 32'(dut.a), 0);
        chk("rst_b", 32'(dut.b), 1);
        rst_n = 1'b1;

        // Full run: clr, ld, then DEPTH cycles of we+up.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("rco_pre", 32'(bus.rco), 32'(i == DEPTH - 1));
            cyc(0, 1, 0, 1, 0);
            if (i == 11) chk("ovf_before", 32'(bus.ovf), 0);
            if (i == 12) chk("ovf_rise", 32'(bus.ovf), 32'(SAT));
        end
        chk("wrap_cnt", 32'(bus.cnt), 0);

        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 0, 0, 0, int'(tbl[i].addr));
            chk($sformatf("ram%0d", i), 32'(bus.rd_data), 32'(tbl[i].exp));
        end
        chk("ovf_sticky", 32'(bus.ovf), 32'(SAT));
        cyc(0, 0, 1, 0, 0);
        chk("ovf_ld_clr", 32'(bus.ovf), 0);

        // clr beats up.
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("clr_up", 32'(bus.cnt), 0);

        // Read-before-write at cnt=3, then ld beating we.
        repeat (3) cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 3);
        cyc(0, 0, 0, 1, 3);
        chk("rbw_old", 32'(bus.rd_data), 2);
        cyc(0, 0, 0, 0, 3);
        chk("rbw_new", 32'(bus.rd_data), 0);
        cyc(0, 0, 0, 1, 3);
        cyc(0, 0, 1, 1, 3);
        chk("ldwe_rd", 32'(bus.rd_data), 1);
        chk("ldwe_a", 32'(dut.a), 0);
        chk("ldwe_b", 32'(dut.b), 1);
        cyc(0, 0, 0, 0, 3);
        chk("ldwe_ram", 32'(bus.rd_data), 1);
        chk("we_hold_cnt", 32'(bus.cnt), 3);

        // Mid-run reset: preload RAM[5]=2, rerun to cnt=5, reset with we pending.
        cyc(1, 0, 1, 0, 0);
        repeat (5) cyc(0, 1, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 1, 0, 0);
        repeat (5) cyc(0, 1, 0, 1, 0);
        chk("pre_rst_cnt", 32'(bus.cnt), 5);
        bus.we = 1; bus.up = 1;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", 32'(bus.cnt), 0);
        chk("arst_a", 32'(dut.a), 0);
        chk("arst_b", 32'(dut.b), 1);
        chk("arst_rd", 32'(bus.rd_data), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            cyc(0, 0, 0, 0, i);
            chk($sformatf("post_rst_ram%0d", i), 32'(bus.rd_data), 32'((i == 5) ? 2 : seq[i]));
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                int'($urandom_range(0, DEPTH - 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
